// File: rtl/pause_arb_pkg.sv
// Shared types and default timing for the pause / high-score RAM arbiter.
package pause_arb_pkg;

    localparam int unsigned DEF_AW          = 12;
    localparam int unsigned DEF_SETTLE      = 16;
    localparam int unsigned DEF_VBL_TIMEOUT = 800000;
    localparam int unsigned DEF_HOLD        = 8;
    localparam int unsigned DEF_DIM_CYCLES  = 300000000;
    localparam int unsigned CNT_W           = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VBL,
        ST_SETTLE,
        ST_GRANT,
        ST_RELEASE
    } arb_state_e;

    // Saturating increment shared by all cycle counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pause_toggle_dim.sv
// User pause button: rising-edge toggle plus optional long-pause dimming.
// Dimming is built only when PAUSE_DIM_EN is defined.
module pause_toggle_dim
    import pause_arb_pkg::*;
#(
    parameter int unsigned DIM_CYCLES = DEF_DIM_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pause_toggle_o,
    output logic dim_video_o
);

    logic btn_q;
    logic toggle_q, toggle_d;

    always_comb begin
        toggle_d = toggle_q;
        if (btn_i && !btn_q) toggle_d = !toggle_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q    <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            btn_q    <= btn_i;
            toggle_q <= toggle_d;
        end
    end

    assign pause_toggle_o = toggle_q;

`ifdef PAUSE_DIM_EN
    logic [CNT_W-1:0] dim_cnt_q, dim_cnt_d;
    logic             dim_q, dim_d;

    // Only the user toggle counts toward dimming; clearing it resets the count.
    always_comb begin
        dim_cnt_d = '0;
        if (toggle_q) begin
            dim_cnt_d = (dim_cnt_q == CNT_W'(DIM_CYCLES)) ? dim_cnt_q : dim_cnt_q + CNT_W'(1);
        end
        dim_d = (dim_cnt_d == CNT_W'(DIM_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_cnt_q <= '0;
            dim_q     <= 1'b0;
        end else begin
            dim_cnt_q <= dim_cnt_d;
            dim_q     <= dim_d;
        end
    end

    assign dim_video_o = dim_q;
`else
    logic unused_dim;
    assign unused_dim  = ^CNT_W'(DIM_CYCLES);
    assign dim_video_o = 1'b0;
`endif

endmodule

// File: rtl/pause_ram_arbiter.sv
// Core pause sequencing and high-score work-RAM arbitration (clk_sys domain).
// Optional dimming of a long user pause is enabled by defining PAUSE_DIM_EN.
module pause_ram_arbiter
    import pause_arb_pkg::*;
#(
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned SETTLE      = DEF_SETTLE,
    parameter int unsigned VBL_TIMEOUT = DEF_VBL_TIMEOUT,
    parameter int unsigned HOLD        = DEF_HOLD,
    parameter int unsigned DIM_CYCLES  = DEF_DIM_CYCLES
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          btn_pause,
    input  logic          osd_open,
    input  logic          osd_pause_en,
    input  logic          vblank,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_we,
    output logic          hs_gnt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    output logic          pause,
    output logic          dim_video
);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vbl_q;
    logic             gnt_q, gnt_d;
    logic             pause_q, pause_d;
    logic             pause_toggle;
    logic             vbl_rise;
    logic             hs_pause;

    pause_toggle_dim #(
        .DIM_CYCLES(DIM_CYCLES)
    ) u_toggle_dim (
        .clk           (clk_sys),
        .rst_n         (reset_n),
        .btn_i         (btn_pause),
        .pause_toggle_o(pause_toggle),
        .dim_video_o   (dim_video)
    );

    // A level already high on entry never counts; only a fresh edge opens the window.
    assign vbl_rise = vblank && !vbl_q;
    assign hs_pause = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = sat_inc(cnt_q);
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (hs_req) state_d = ST_WAIT_VBL;
            end
            ST_WAIT_VBL: begin
                if (!hs_req) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (vbl_rise || (cnt_q >= CNT_W'(VBL_TIMEOUT - 1))) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!hs_req) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(SETTLE - 1)) begin
                    state_d = ST_GRANT;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                cnt_d = '0;
                if (!hs_req) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cnt_q >= CNT_W'(HOLD - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        gnt_d   = (state_d == ST_GRANT);
        pause_d = hs_pause || pause_toggle || (osd_open && osd_pause_en);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vbl_q   <= 1'b0;
            gnt_q   <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vbl_q   <= vblank;
            gnt_q   <= gnt_d;
            pause_q <= pause_d;
        end
    end

    // CPU writes are dropped while granted: the core is paused so none are pending.
    assign ram_addr  = gnt_q ? hs_addr  : cpu_addr;
    assign ram_wdata = gnt_q ? hs_wdata : cpu_wdata;
    assign ram_we    = gnt_q ? hs_we    : cpu_we;

    assign hs_gnt = gnt_q;
    assign pause  = pause_q;

endmodule
